// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate adder that resolves a {pc, ps} carry-save pair CHUNK_WIDTH bits
// per cycle. Define CSA_RESOLVER_CARRY_EN to add the registered out_carry port.
module csa_resolver #(
  parameter int unsigned DATA_WIDTH  = 63,
  parameter int unsigned CHUNK_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_sum
`ifdef CSA_RESOLVER_CARRY_EN
  ,
  output logic                      out_carry
`endif
);

  localparam int unsigned NumChunks = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int unsigned PadWidth  = NumChunks * CHUNK_WIDTH;
  localparam int unsigned LastWidth = DATA_WIDTH - (NumChunks - 1) * CHUNK_WIDTH;
  localparam int unsigned IdxWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumChunks - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e                state_q, state_d;
  logic [PadWidth-1:0]   ps_q, ps_d;
  logic [PadWidth-1:0]   pc_q, pc_d;
  logic [PadWidth-1:0]   res_q, res_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`ifdef CSA_RESOLVER_CARRY_EN
  logic                  cout_q, cout_d;
`endif

  logic [CHUNK_WIDTH:0]  chunk_sum;
  logic                  last_chunk;
  logic                  chunk_cout;

  // Operands shift right one chunk per cycle, so the current chunk always sits at bit 0.
  assign chunk_sum  = {1'b0, ps_q[CHUNK_WIDTH-1:0]} + {1'b0, pc_q[CHUNK_WIDTH-1:0]}
                    + {{CHUNK_WIDTH{1'b0}}, carry_q};
  assign last_chunk = (idx_q == LastIdx);
  // The last chunk is zero-padded above LastWidth, so its true carry lands at bit LastWidth.
  assign chunk_cout = last_chunk ? chunk_sum[LastWidth] : chunk_sum[CHUNK_WIDTH];

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    pc_d    = pc_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
`ifdef CSA_RESOLVER_CARRY_EN
    cout_d  = cout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          ps_d    = PadWidth'(in_data[DATA_WIDTH-1:0]);
          pc_d    = PadWidth'(in_data[2*DATA_WIDTH-1:DATA_WIDTH]);
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        ps_d    = ps_q >> CHUNK_WIDTH;
        pc_d    = pc_q >> CHUNK_WIDTH;
        // Result fills from the top; after NumChunks shifts chunk k rests at slice k.
        res_d   = res_q >> CHUNK_WIDTH;
        res_d[PadWidth-1 -: CHUNK_WIDTH] = chunk_sum[CHUNK_WIDTH-1:0];
        carry_d = chunk_cout;
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          sum_d   = res_d[DATA_WIDTH-1:0];
`ifdef CSA_RESOLVER_CARRY_EN
          cout_d  = chunk_cout;
`endif
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ps_q    <= '0;
      pc_q    <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
`ifdef CSA_RESOLVER_CARRY_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      pc_q    <= pc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
`ifdef CSA_RESOLVER_CARRY_EN
      cout_q  <= cout_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_sum   = sum_q;
`ifdef CSA_RESOLVER_CARRY_EN
  assign out_carry = cout_q;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: default instance (CHUNK_WIDTH=16) and single-chunk instance
// (CHUNK_WIDTH=63), checked against plain 64-bit addition.
module tb_csa_resolver;

  logic         clk;
  logic         rst       [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [125:0] in_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [62:0]  out_sum   [2];
`ifdef CSA_RESOLVER_CARRY_EN
  logic         out_carry [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  csa_resolver #(.DATA_WIDTH(63), .CHUNK_WIDTH(16)) dut0 (
    .clk       (clk),
    .rst       (rst[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_sum   (out_sum[0])
`ifdef CSA_RESOLVER_CARRY_EN
    ,
    .out_carry (out_carry[0])
`endif
  );

  csa_resolver #(.DATA_WIDTH(63), .CHUNK_WIDTH(63)) dut1 (
    .clk       (clk),
    .rst       (rst[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_sum   (out_sum[1])
`ifdef CSA_RESOLVER_CARRY_EN
    ,
    .out_carry (out_carry[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int chunks_of(input int i);
    int cw;
    cw = (i == 0) ? 16 : 63;
    return (63 + cw - 1) / cw;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accept edge; checks latency, result and output handshake.
  task automatic wait_result(input int i, input logic [63:0] full, input int hold);
    int cnt;
    logic [62:0] exp_sum;
    exp_sum = full[62:0];
    out_ready[i] = (hold == 0);
    cnt = 0;
    while (!out_valid[i] && cnt < 40) begin
      step();
      cnt++;
    end
    check("latency", 64'(cnt), 64'(chunks_of(i)));
    check("out_sum", 64'(out_sum[i]), 64'(exp_sum));
`ifdef CSA_RESOLVER_CARRY_EN
    check("out_carry", 64'(out_carry[i]), 64'(full[63]));
`endif
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", 64'(out_valid[i]), 64'd1);
      check("hold_sum", 64'(out_sum[i]), 64'(exp_sum));
      check("hold_in_ready", 64'(in_ready[i]), 64'd0);
    end
    out_ready[i] = 1'b1;
    step();
    check("valid_drop", 64'(out_valid[i]), 64'd0);
    check("ready_rise", 64'(in_ready[i]), 64'd1);
    check("sum_kept", 64'(out_sum[i]), 64'(exp_sum));
    out_ready[i] = 1'b0;
  endtask

  task automatic do_op(input int i, input logic [62:0] ps, input logic [62:0] pc,
                       input int hold);
    int cnt;
    logic [63:0] junk;
    cnt = 0;
    while (!in_ready[i] && cnt < 20) begin
      step();
      cnt++;
    end
    check("in_ready_wait", 64'(in_ready[i]), 64'd1);
    in_valid[i] = 1'b1;
    in_data[i]  = {pc, ps};
    step();
    in_valid[i] = 1'b0;
    junk = {$urandom, $urandom};
    in_data[i] = {junk[62:0], junk[63:1]};
    wait_result(i, {1'b0, ps} + {1'b0, pc}, hold);
  endtask

  logic [63:0] r0, r1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = '0;
    end
    #3;
    check("rst_in_ready", 64'(in_ready[0]), 64'd1);
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_out_sum", 64'(out_sum[0]), 64'd0);
`ifdef CSA_RESOLVER_CARRY_EN
    check("rst_out_carry", 64'(out_carry[0]), 64'd0);
`endif
    step();
    step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();

    // Directed cases
    do_op(0, 63'd1, 63'd1, 0);
    do_op(0, {63{1'b1}}, 63'd1, 0);
    do_op(0, 63'h0000_0000_0000_FFFF, 63'd1, 0);
    do_op(0, 63'h0000_FFFF_FFFF_FFFF, 63'h0000_0000_0000_0001, 2);

    // Backpressure with a new pair waiting on in_valid
    in_valid[0] = 1'b1;
    in_data[0]  = {63'd4, 63'd3};
    step();
    in_data[0]  = {63'd20, 63'd10};
    wait_result(0, 64'd7, 5);
    step();
    in_valid[0] = 1'b0;
    check("bp_accepted", 64'(in_ready[0]), 64'd0);
    wait_result(0, 64'd30, 0);

    // Reset while chunk 2 is in flight
    in_valid[0] = 1'b1;
    in_data[0]  = {63'h456, 63'h123};
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    rst[0] = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    check("midrst_out_sum", 64'(out_sum[0]), 64'd0);
    step();
    rst[0] = 1'b0;
    step();
    check("post_rst_valid", 64'(out_valid[0]), 64'd0);
    do_op(0, 63'd5, 63'd7, 0);

    // Single-chunk corner
    do_op(1, {63{1'b1}}, {63{1'b1}}, 0);
    do_op(1, 63'd5, 63'd7, 1);

    // Randomized operands and backpressure
    for (int n = 0; n < 16; n++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      if (n % 4 == 3) r1 = ~r0 + 64'(n % 2);
      do_op(0, r0[62:0], r1[62:0], int'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 6; n++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      do_op(1, r0[62:0], r1[62:0], int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
